ks_step45_sum: RTL and testbench

Final stages of the 25-bit Kogge-Stone mantissa adder in the floating-point MAC datapath. Sits directly downstream of the span-4 prefix stage and consumes its registered outputs. It performs the distance-8 prefix stage and the distance-16 prefix stage, then forms the sum and carry-out. It is a 2-stage registered pipeline with valid tracking and a global stall, feeding the normaliser.

---
 rtl/ks_step45_sum.sv | 82 ++++++++
 tb/tb_ks_step45_sum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ks_step45_sum.sv
// Distance-8 and distance-16 Kogge-Stone prefix stages of the 25-bit mantissa
// adder, followed by sum/carry-out formation. Two registered stages, global stall.
module ks_step45_sum (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [24:0] G3,
  input  logic [24:0] P3,
  input  logic [24:0] P0,
  input  logic [24:0] in_GG,
  input  logic        in_sign,
  output logic [24:0] out_sum,
  output logic        out_cout,
  output logic        out_sign,
  output logic        out_valid
);

  // Valid semantics: in_valid qualifies the bundle sampled on an edge with
  // enable=1; out_valid qualifies the registered outputs. There is no ready:
  // enable=0 freezes both stages (data and valid bits) for the whole pipe.

  // Stage A: complete prefixes for bits 15:0, span-16 groups for bits 24:16
  logic [15:0]  gga_d, gga_q;
  logic [24:16] ga_d, ga_q;
  logic [24:16] pa_d, pa_q;
  logic [24:0]  p0a_q;
  logic         sign_a_q, valid_a_q;

  always_comb begin
    gga_d[7:0]  = in_GG[7:0];
    gga_d[15:8] = G3[15:8] | (P3[15:8] & in_GG[7:0]);
    ga_d        = G3[24:16] | (P3[24:16] & G3[16:8]);
    pa_d        = P3[24:16] & P3[16:8];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gga_q     <= '0;
      ga_q      <= '0;
      pa_q      <= '0;
      p0a_q     <= '0;
      sign_a_q  <= 1'b0;
      valid_a_q <= 1'b0;
    end else if (enable) begin
      gga_q     <= gga_d;
      ga_q      <= ga_d;
      pa_q      <= pa_d;
      p0a_q     <= P0;
      sign_a_q  <= in_sign;
      valid_a_q <= in_valid;
    end
  end

  // Stage B: finish the carry prefix; bit i's carry-in is the prefix of bit i-1
  logic [24:0] ggb;
  logic [24:0] sum_d;

  always_comb begin
    ggb   = {ga_q | (pa_q & gga_q[8:0]), gga_q};
    sum_d = {p0a_q[24:1] ^ ggb[23:0], p0a_q[0]};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_sign  <= 1'b0;
      out_valid <= 1'b0;
    end else if (enable) begin
      out_sum   <= sum_d;
      out_cout  <= ggb[24];
      out_sign  <= sign_a_q;
      out_valid <= valid_a_q;
    end
  end

  // Input bits that are don't-care at this stage
  logic unused_bits;
  assign unused_bits = ^{G3[7:0], P3[7:0], in_GG[24:8]};

endmodule

// File: tb/tb_ks_step45_sum.sv
// Bench for ks_step45_sum: operands go through a reference model of the upstream
// prefix stages; results are checked in order against an expected queue.
module tb_ks_step45_sum;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic        in_valid;
  logic [24:0] G3, P3, P0, in_GG;
  logic        in_sign;
  logic [24:0] out_sum;
  logic        out_cout, out_sign, out_valid;

  ks_step45_sum dut (
    .clock(clock), .resetn(resetn), .enable(enable), .in_valid(in_valid),
    .G3(G3), .P3(P3), .P0(P0), .in_GG(in_GG), .in_sign(in_sign),
    .out_sum(out_sum), .out_cout(out_cout), .out_sign(out_sign),
    .out_valid(out_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [26:0] exp_q[$];       // {sign, cout, sum}
  logic [26:0] pending_exp;
  logic [27:0] prev_out;       // {valid, sign, cout, sum}
  logic        adv;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  typedef struct {
    logic [24:0] a;
    logic [24:0] b;
    logic        sign;
    logic [24:0] exp_sum;
    logic        exp_cout;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got %h exp %h", name, got, exp);
  endtask

  // Group generate/propagate over bits hi..lo, built serially
  function automatic logic [1:0] grp(input logic [24:0] g, input logic [24:0] p,
                                     input int hi, input int lo);
    logic gg, pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int k = lo; k <= hi; k++) begin
      gg = g[k] | (p[k] & gg);
      pp = pp & p[k];
    end
    return {gg, pp};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [24:0] a, input logic [24:0] b,
                       input logic s, input logic v);
    logic [24:0] g, p;
    logic [1:0]  gp;
    logic [25:0] full;
    g = a & b;
    p = a ^ b;
    for (int i = 0; i < 25; i++) begin
      if (i >= 8) begin
        gp       = grp(g, p, i, i - 7);
        G3[i]    = gp[1];
        P3[i]    = gp[0];
        in_GG[i] = 1'($urandom_range(0, 1));
      end else begin
        gp       = grp(g, p, i, 0);
        G3[i]    = gp[1];
        P3[i]    = 1'($urandom_range(0, 1));
        in_GG[i] = gp[1];
      end
    end
    P0          = p;
    in_sign     = s;
    in_valid    = v;
    full        = {1'b0, a} + {1'b0, b};
    pending_exp = {s, full};
  endtask

  // One clock: enqueue the accepted bundle, then check outputs at the negedge
  task automatic step();
    logic [27:0] cur;
    logic [26:0] e;
    if (in_valid && enable && resetn) exp_q.push_back(pending_exp);
    @(posedge clock);
    adv = enable;
    @(negedge clock);
    cur = {out_valid, out_sign, out_cout, out_sum};
    if (adv) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", {5'd0, cur[26:0]}, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          check("sb_result", {5'd0, cur[26:0]}, {5'd0, e});
        end
      end
    end else begin
      check("stall_hold", {4'd0, cur}, {4'd0, prev_out});
    end
    prev_out = cur;
  endtask

  task automatic check_zero(input string name);
    check(name, {4'd0, out_valid, out_sign, out_cout, out_sum}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{25'h1FFFFFF, 25'h0000001, 1'b0, 25'h0000000, 1'b1};
    vecs[1] = '{25'h0AAAAAA, 25'h1555555, 1'b1, 25'h1FFFFFF, 1'b0};
    vecs[2] = '{25'h0FFFFFF, 25'h0000001, 1'b1, 25'h1000000, 1'b0};
    vecs[3] = '{25'h1000000, 25'h1000000, 1'b0, 25'h0000000, 1'b1};
    vecs[4] = '{25'd5,       25'd7,       1'b1, 25'd12,      1'b0};
    vecs[5] = '{25'd100,     25'd23,      1'b0, 25'd123,     1'b0};
    vecs[6] = '{25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 25'h1FFFFFE, 1'b1};
    vecs[7] = '{25'h00000FF, 25'h0000101, 1'b0, 25'h0000200, 1'b0};

    resetn = 1'b0;
    enable = 1'b0;
    adv    = 1'b0;
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    #3;
    check_zero("reset_state");
    prev_out = '0;
    resetn = 1'b1;
    enable = 1'b1;

    // Test 1: full-length carry, explicit latency
    drive(25'h1FFFFFF, 25'h0000001, 1'b0, 1'b1);
    step();
    check("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    step();
    check("t1_result", {5'd0, out_valid, out_cout, out_sum}, {5'd0, 1'b1, 1'b1, 25'h0});
    step();

    // Table vectors back-to-back, expected values taken from the table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sign, 1'b1);
      pending_exp = {vecs[i].sign, vecs[i].exp_cout, vecs[i].exp_sum};
      step();
    end
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    step();
    step();
    check("table_drained", exp_q.size(), 32'd0);

    // Test 4: stall with a bundle in flight
    drive(25'd100, 25'd23, 1'b1, 1'b1);
    step();
    drive(25'd1, 25'd1, 1'b0, 1'b1);
    enable = 1'b0;
    repeat (3) step();
    check("t4_frozen_invalid", {31'd0, out_valid}, 32'd0);
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    check("t4_result", {5'd0, out_valid, out_sign, out_sum}, {5'd0, 1'b1, 1'b1, 25'd123});
    step();
    check("t4_once", {31'd0, out_valid}, 32'd0);

    // Test 5: async reset with two bundles in flight
    drive(25'd7, 25'd9, 1'b1, 1'b1);
    step();
    drive(25'd11, 25'd13, 1'b1, 1'b1);
    step();
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1 check_zero("t5_async_reset");
    exp_q.delete();
    prev_out = '0;
    #1 resetn = 1'b1;
    repeat (3) step();
    check("t5_no_stale", {31'd0, out_valid}, 32'd0);
    drive(25'd40, 25'd2, 1'b0, 1'b1);
    step();
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    step();
    check("t5_first_after_reset", {6'd0, out_valid, out_sum}, {6'd0, 1'b1, 25'd42});

    // Reset while stalled: registers stay zero
    enable = 1'b0;
    resetn = 1'b0;
    #1 check_zero("stalled_reset");
    prev_out = '0;
    exp_q.delete();
    step();
    resetn = 1'b1;
    step();
    check_zero("stalled_reset_release");
    enable = 1'b1;

    // Test 6: random stream with random stalls
    for (int n = 0; n < 10000; n++) begin
      drive(25'($urandom_range(0, 32'h1FFFFFF)), 25'($urandom_range(0, 32'h1FFFFFF)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      enable = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(25'd0, 25'd0, 1'b0, 1'b0);
    enable = 1'b1;
    repeat (3) step();
    check("random_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
